// File: rtl/insn_encoder_if.sv
// rtl/insn_encoder_if.sv - request/response bundle for the RV32I instruction encoder
interface insn_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              addr_clr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_insn;
  logic [ADDR_W-1:0] out_addr;
  logic              err_pulse;
  logic [7:0]        err_count;

  // program generator side: issues requests, consumes words
  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, addr_clr, out_ready,
    input  in_ready, out_valid, out_insn, out_addr, err_pulse, err_count
  );

  // encoder side
  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, addr_clr, out_ready,
    output in_ready, out_valid, out_insn, out_addr, err_pulse, err_count
  );
endinterface

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - streaming RV32I field-to-word encoder with address counter (optional ENC_IMM_CHECK_EN)
module insn_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic           clk,
  input logic           rst_n,
  insn_encoder_if.slave bus
);
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0]       insn;
  logic              fmt_ok;
  logic              imm_ok;
  logic              accept;
  logic              take;
  logic              reject;
  logic              out_valid_q;
  logic [31:0]       out_insn_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] word_addr;
  logic              err_pulse_q;
  logic [7:0]        err_count_q;

  // pack request fields into the standard RV32I bit placement
  always_comb begin
    insn   = 32'h0;
    fmt_ok = 1'b1;
    case (bus.fmt)
      FMT_R: insn = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I: insn = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_S: insn = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      FMT_B: insn = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[4:1], bus.imm[11], bus.opcode};
      FMT_U: insn = {bus.imm[31:12], bus.rd, bus.opcode};
      FMT_J: insn = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                     bus.rd, bus.opcode};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  // immediate must be representable: sign-extension bits all equal, alignment where needed
  always_comb begin
    imm_ok = 1'b1;
    case (bus.fmt)
      FMT_I, FMT_S: imm_ok = (bus.imm[31:11] == '0) || (bus.imm[31:11] == '1);
      FMT_B: imm_ok = ((bus.imm[31:12] == '0) || (bus.imm[31:12] == '1)) && !bus.imm[0];
      FMT_J: imm_ok = ((bus.imm[31:20] == '0) || (bus.imm[31:20] == '1)) && !bus.imm[0];
      FMT_U: imm_ok = (bus.imm[11:0] == 12'h000);
      default: imm_ok = 1'b1;
    endcase
  end
`else
  // out-of-range immediates are truncated silently
  always_comb begin
    imm_ok = 1'b1;
  end
`endif

  // handshake: the output register can take a word when empty or draining
  always_comb begin
    bus.in_ready = !out_valid_q || bus.out_ready;
    accept       = bus.in_valid && bus.in_ready;
    take         = accept && fmt_ok && imm_ok;
    reject       = accept && !(fmt_ok && imm_ok);
    word_addr    = bus.addr_clr ? BASE_ADDR : next_addr;
  end

  // output register, address counter and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_insn_q  <= 32'h0;
      out_addr_q  <= BASE_ADDR;
      next_addr   <= BASE_ADDR;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      if (take) begin
        out_valid_q <= 1'b1;
        out_insn_q  <= insn;
        out_addr_q  <= word_addr;
        next_addr   <= word_addr + ADDR_W'(4);
      end else begin
        if (bus.out_ready) out_valid_q <= 1'b0;
        if (bus.addr_clr)  next_addr   <= BASE_ADDR;
      end
      err_pulse_q <= reject;
      if (reject && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_insn  = out_insn_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_insn_encoder.sv
// tb/tb_insn_encoder.sv - directed self-checking bench for insn_encoder
module tb_insn_encoder;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  insn_encoder_if #(.ADDR_W(32)) bus ();

  insn_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                     input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [6:0] f7, input logic [31:0] im);
    bus.in_valid = 1'b1;
    bus.fmt      = f;
    bus.opcode   = op;
    bus.rd       = d;
    bus.funct3   = f3;
    bus.rs1      = s1;
    bus.rs2      = s2;
    bus.funct7   = f7;
    bus.imm      = im;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.addr_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.fmt = 3'd0; bus.opcode = 7'h0; bus.rd = 5'd0; bus.funct3 = 3'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.funct7 = 7'h0; bus.imm = 32'h0;
    bus.addr_clr = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    #1;

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_insn",  64'(bus.out_insn),  64'd0);
    check("rst_out_addr",  64'(bus.out_addr),  64'd0);
    check("rst_err_pulse", 64'(bus.err_pulse), 64'd0);
    check("rst_err_count", 64'(bus.err_count), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // R-type add x3, x1, x2
    req(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h0);
    step();
    idle();
    check("add_valid", 64'(bus.out_valid), 64'd1);
    check("add_insn",  64'(bus.out_insn),  64'h002081B3);
    check("add_addr",  64'(bus.out_addr),  64'h0);
    step();
    check("add_drained", 64'(bus.out_valid), 64'd0);

    // back-to-back addi, sw, lui after reset
    do_reset();
    req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    step();
    check("addi_insn", 64'(bus.out_insn), 64'h00500093);
    check("addi_addr", 64'(bus.out_addr), 64'h0);
    req(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'd8);
    step();
    check("sw_insn", 64'(bus.out_insn), 64'h0020A423);
    check("sw_addr", 64'(bus.out_addr), 64'h4);
    req(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000);
    step();
    check("lui_insn",  64'(bus.out_insn),  64'h123452B7);
    check("lui_addr",  64'(bus.out_addr),  64'h8);
    check("lui_valid", 64'(bus.out_valid), 64'd1);
    req(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'hFFFF_FFFC);
    step();
    check("beq_insn", 64'(bus.out_insn), 64'hFE208EE3);
    check("beq_addr", 64'(bus.out_addr), 64'hC);
    req(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd8);
    step();
    idle();
    check("jal_insn", 64'(bus.out_insn), 64'h008000EF);
    check("jal_addr", 64'(bus.out_addr), 64'h10);
    step();

    // backpressure: word held while the next request waits
    do_reset();
    req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    step();
    bus.out_ready = 1'b0;
    req(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'd8);
    #1;
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_insn", 64'(bus.out_insn), 64'h00500093);
      check("bp_hold_addr", 64'(bus.out_addr), 64'h0);
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    step();
    idle();
    check("bp_next_valid", 64'(bus.out_valid), 64'd1);
    check("bp_next_insn",  64'(bus.out_insn),  64'h0020A423);
    check("bp_next_addr",  64'(bus.out_addr),  64'h4);
    step();
    check("bp_drain", 64'(bus.out_valid), 64'd0);

    // illegal format handling
    do_reset();
    req(3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    step();
    idle();
    check("ill_no_valid", 64'(bus.out_valid), 64'd0);
    check("ill_pulse",    64'(bus.err_pulse), 64'd1);
    check("ill_count",    64'(bus.err_count), 64'd1);
    step();
    check("ill_pulse_end", 64'(bus.err_pulse), 64'd0);
    req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    step();
    idle();
    check("ill_addr_kept", 64'(bus.out_addr), 64'h0);
    req(3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    repeat (256) step();
    idle();
    check("sat_count", 64'(bus.err_count), 64'd255);
    check("sat_no_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("sat_hold", 64'(bus.err_count), 64'd255);

    // addr_clr with a simultaneous legal request
    req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    step();
    check("pre_clr_addr", 64'(bus.out_addr), 64'h4);
    req(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'd8);
    bus.addr_clr = 1'b1;
    step();
    bus.addr_clr = 1'b0;
    check("clr_addr", 64'(bus.out_addr), 64'h0);
    check("clr_insn", 64'(bus.out_insn), 64'h0020A423);
    req(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000);
    step();
    idle();
    check("post_clr_addr", 64'(bus.out_addr), 64'h4);

    // reset while a word is held discards it
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_addr",  64'(bus.out_addr),  64'h0);
    check("midrst_count", 64'(bus.err_count), 64'd0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;

    // I-type immediate out of the 12-bit range
    req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd4096);
    step();
    idle();
`ifdef ENC_IMM_CHECK_EN
    check("immchk_no_valid", 64'(bus.out_valid), 64'd0);
    check("immchk_count",    64'(bus.err_count), 64'd1);
    check("immchk_pulse",    64'(bus.err_pulse), 64'd1);
`else
    check("trunc_valid", 64'(bus.out_valid), 64'd1);
    check("trunc_insn",  64'(bus.out_insn),  64'h00000093);
    check("trunc_count", 64'(bus.err_count), 64'd0);
`endif
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
